// File: rtl/transpose_pkg.sv
// transpose_pkg: shared tile-loader types and width helpers.
package transpose_pkg;
  typedef enum logic {FILL, HOLD} state_t;
  function automatic int chunk_width(input int dw, input int pe, input int mg);
    return mg / pe * dw;
  endfunction
  function automatic int row_bits(input int pe);
    return pe > 1 ? $clog2(pe) : 1;
  endfunction
endpackage

// File: rtl/tile_bank.sv
// tile_bank: NUM_PE x NUM_PE chunk register array written one row at a time, no reset on data.
module tile_bank import transpose_pkg::*; #(
  parameter int NUM_PE = 8,
  parameter int CHUNK_WIDTH = 64,
  localparam int RW = row_bits(NUM_PE)
) (
  input logic clk,
  input logic we,
  input logic [RW-1:0] row,
  input logic [NUM_PE-1:0][CHUNK_WIDTH-1:0] wdata,
  output logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] tile
);
  always_ff @(posedge clk)
    if (we) tile[row] <= wdata;
endmodule

// File: rtl/transpose_tile_loader.sv
// transpose_tile_loader: gathers NUM_PE rows into a tile for the switch network.
// Define TILE_LOADER_DOUBLE_BUF_EN for ping-pong banks (fill one while the other is presented).
module transpose_tile_loader import transpose_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE = 8,
  parameter int NUM_MG = 8,
  localparam int CHUNK_WIDTH = chunk_width(DATA_WIDTH, NUM_PE, NUM_MG),
  localparam int RW = row_bits(NUM_PE)
) (
  input logic clk,
  input logic rst,
  input logic abort,
  input logic in_valid,
  output logic in_ready,
  input logic [NUM_PE-1:0][CHUNK_WIDTH-1:0] in_row,
  output logic out_valid,
  input logic out_ready,
  output logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] out_tile,
  output logic ctrl
);
  logic [RW-1:0] cnt;
  logic accept, done, fire, ctrl_n;
  assign accept = in_valid & in_ready & ~abort;
  assign done = accept & (cnt == RW'(NUM_PE - 1));
  assign fire = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      ctrl <= 1'b0;
    end else begin
      cnt <= (abort || done) ? '0 : accept ? cnt + 1'b1 : cnt;
      ctrl <= ctrl_n;
    end
`ifdef TILE_LOADER_DOUBLE_BUF_EN
  logic wp, rp;
  logic [1:0] full, full_n;
  logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] tiles [2];
  for (genvar i = 0; i < 2; i++) begin : g_bank
    tile_bank #(.NUM_PE(NUM_PE), .CHUNK_WIDTH(CHUNK_WIDTH)) u_bank (
      .clk,
      .we(accept && wp == 1'(i)),
      .row(cnt),
      .wdata(in_row),
      .tile(tiles[i])
    );
  end
  // a bank can be consumed and the other completed in the same cycle
  always_comb begin
    full_n = full;
    for (int i = 0; i < 2; i++)
      full_n[i] = (full[i] & ~(fire && rp == 1'(i))) | (done && wp == 1'(i));
    ctrl_n = full_n[rp ^ fire] & (~out_valid | fire);
  end
  assign in_ready = ~&full;
  assign out_valid = full[rp];
  assign out_tile = tiles[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      full <= '0;
    end else begin
      wp <= wp ^ done;
      rp <= rp ^ fire;
      full <= full_n;
    end
`else
  state_t state, state_n;
  tile_bank #(.NUM_PE(NUM_PE), .CHUNK_WIDTH(CHUNK_WIDTH)) u_bank (
    .clk,
    .we(accept),
    .row(cnt),
    .wdata(in_row),
    .tile(out_tile)
  );
  always_comb begin
    state_n = state == FILL ? (done ? HOLD : FILL) : (fire ? FILL : HOLD);
    ctrl_n = state == FILL && state_n == HOLD;
  end
  assign in_ready = state == FILL;
  assign out_valid = state == HOLD;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FILL;
    else state <= state_n;
`endif
endmodule

// File: tb/tb_transpose_tile_loader.sv
// tb_transpose_tile_loader: directed and random stimulus checked against a row/tile queue model.
module tb_transpose_tile_loader;
  import transpose_pkg::*;
  localparam int DW = 64, PE = 8, MG = 8;
  localparam int CW = chunk_width(DW, PE, MG);
  localparam int L = PE * CW;
`ifdef TILE_LOADER_DOUBLE_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef logic [PE-1:0][CW-1:0] row_t;
  typedef logic [PE-1:0][PE-1:0][CW-1:0] tile_t;

  logic clk = 1'b0, rst = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, ctrl;
  row_t in_row = '0;
  tile_t out_tile;
  int n_checks = 0, n_fail = 0, n_ctrl = 0, base;

  tile_t q[$];
  tile_t part;
  int pcnt = 0;
  logic m_ctrl = 1'b0;

  always #5 clk = ~clk;

  transpose_tile_loader #(.DATA_WIDTH(DW), .NUM_PE(PE), .NUM_MG(MG)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_tile(out_tile), .ctrl(ctrl)
  );

  task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic row_t pat(input int r);
    row_t x;
    for (int k = 0; k < PE; k++) x[k] = CW'(16 * r + k);
    return x;
  endfunction

  function automatic row_t rnd_row();
    row_t x;
    for (int k = 0; k < PE; k++) x[k] = CW'({$urandom(), $urandom()});
    return x;
  endfunction

  // one clock: check outputs against the model, then advance the model at the edge
  task automatic cyc(input logic v, input logic a, input logic o, input row_t r);
    logic acc, fire, was;
    in_valid = v; abort = a; out_ready = o; in_row = r;
    @(negedge clk);
    check("in_ready", L'(in_ready), L'(q.size() < CAP));
    check("out_valid", L'(out_valid), L'(q.size() > 0));
    check("ctrl", L'(ctrl), L'(m_ctrl));
    if (ctrl) n_ctrl++;
    if (q.size() > 0)
      for (int i = 0; i < PE; i++) check($sformatf("tile_row%0d", i), out_tile[i], q[0][i]);
    was = q.size() > 0;
    acc = v && q.size() < CAP && !a;
    fire = was && o;
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (a) pcnt = 0;
    else if (acc) begin
      part[pcnt] = r;
      pcnt++;
      if (pcnt == PE) begin
        q.push_back(part);
        pcnt = 0;
      end
    end
    m_ctrl = q.size() > 0 && (!was || fire);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", L'(out_valid), L'(0));
    check("rst_in_ready", L'(in_ready), L'(1));
    check("rst_ctrl", L'(ctrl), L'(0));
    q.delete(); pcnt = 0; m_ctrl = 1'b0;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rows(input int first, input int n, input logic o);
    for (int r = first; r < first + n; r++) cyc(1'b1, 1'b0, o, pat(r));
  endtask

  initial begin
    do_reset();
    base = n_ctrl;
    rows(0, 8, 1'b0);
    check("tile_3_5", L'(out_tile[3][5]), L'(8'h35));
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, rnd_row());
    check("hold_ctrl_pulses", L'(n_ctrl - base), L'(1));
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    rows(0, 3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    rows(8, 8, 1'b0);
    check("abort_row0", L'(out_tile[0][0]), L'(8'h80));
    cyc(1'b0, 1'b0, 1'b1, '0);
    rows(0, 5, 1'b0);
    do_reset();
    rows(2, 8, 1'b0);
    check("post_rst_row0", L'(out_tile[0][1]), L'(8'h21));
    cyc(1'b0, 1'b0, 1'b1, '0);
    rows(0, 7, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, pat(7));
    cyc(1'b0, 1'b0, 1'b0, '0);
    rows(4, 8, 1'b0);
    check("abort_last_row0", L'(out_tile[0][0]), L'(8'h40));
    cyc(1'b0, 1'b0, 1'b1, '0);
`ifdef TILE_LOADER_DOUBLE_BUF_EN
    cyc(1'b0, 1'b0, 1'b0, '0);
    base = n_ctrl;
    rows(0, 24, 1'b0);
    check("dbuf_in_ready_low", L'(in_ready), L'(0));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, '0);
    check("dbuf_ctrl_pulses", L'(n_ctrl - base), L'(2));
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else cyc(1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0),
               1'($urandom_range(1)), rnd_row());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/transpose_tile_loader.md
TRANSPOSE_TILE_LOADER -- requirements
Module: transpose_tile_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: element width in bits.
REQ-002 SHALL have parameter NUM_PE, default 8: rows per tile and chunks per row.
REQ-003 SHALL have parameter NUM_MG, default 8: merge-group count; CHUNK_WIDTH = NUM_MG/NUM_PE*DATA_WIDTH.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port abort, input, 1: synchronous discard of any partially filled tile.
REQ-007 SHALL have port in_valid, input, 1: in_row holds a valid row.
REQ-008 SHALL have port in_ready, output, 1: loader accepts a row this cycle.
REQ-009 SHALL have port in_row, input, NUM_PE x CHUNK_WIDTH: one tile row, chunk index k.
REQ-010 SHALL have port out_valid, output, 1: out_tile holds a complete tile.
REQ-011 SHALL have port out_ready, input, 1: the switch network consumes the tile.
REQ-012 SHALL have port out_tile, output, NUM_PE x NUM_PE x CHUNK_WIDTH: tile indexed [row][chunk], matching the switch input_elements layout.
REQ-013 SHALL have port ctrl, output, 1: one-cycle start pulse to the switch network.

Function
REQ-014 SHALL accept a row only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL write the r-th accepted row of a tile to out_tile[r][0..NUM_PE-1], using a row counter 0..NUM_PE-1 that wraps to 0 after NUM_PE-1.
REQ-016 SHALL implement states FILL and HOLD; FILL to HOLD on acceptance of row NUM_PE-1; HOLD to FILL on out_valid and out_ready.
REQ-017 SHALL assert out_valid the cycle after row NUM_PE-1 is accepted, with a fill-to-present latency of 1 cycle.
REQ-018 SHALL hold out_valid and out_tile stable until out_valid and out_ready are both 1.
REQ-019 SHALL pulse ctrl high for exactly one cycle, on the first cycle of each tile's out_valid.
REQ-020 SHALL keep in_ready at 1 in FILL and at 0 in HOLD when DOUBLE_BUF_EN is undefined.
REQ-021 SHALL, on abort, reset the fill row counter to 0 and discard partial rows, leaving any presented tile and out_valid unaffected.
REQ-022 SHALL give abort priority over a same-cycle row acceptance, so that row is dropped.
REQ-023 SHALL leave unwritten out_tile contents undefined but stable.

Reset
REQ-024 SHALL, on rst low, immediately set state FILL, row counter 0, out_valid 0, ctrl 0, in_ready 1 and bank pointers 0.
REQ-025 SHALL not reset the out_tile data storage.
REQ-026 SHALL discard any partial tile when rst is asserted mid-fill; the first row after release is row 0.

Configuration
REQ-027 SHALL, when macro TILE_LOADER_DOUBLE_BUF_EN is defined, provide two tile banks in ping-pong: fill one bank while the other is presented.
REQ-028 SHALL, with TILE_LOADER_DOUBLE_BUF_EN defined, drop in_ready only when both banks are full.
REQ-029 SHALL, with TILE_LOADER_DOUBLE_BUF_EN defined, present a completed tile on the cycle after the previous tile is consumed, with ctrl pulsing again.
REQ-030 SHALL, with TILE_LOADER_DOUBLE_BUF_EN defined, support simultaneous row acceptance and tile consumption without loss.
REQ-031 SHALL, without TILE_LOADER_DOUBLE_BUF_EN, use a single bank with behaviour per REQ-020.

Structure
REQ-032 SHALL take the state enum (FILL, HOLD) and the CHUNK_WIDTH derivation from shared package transpose_pkg.
REQ-033 SHALL instantiate one sub-module, tile_bank: one NUM_PE x NUM_PE register array with a row write port, instantiated once or twice per configuration.

Verification
REQ-034 SHALL cover: 8 rows at in_valid=1 with row r chunk k = 16*r+k -> out_valid at cycle 9, out_tile[3][5]=0x35, ctrl one pulse.
REQ-035 SHALL cover: HOLD with out_ready=0 for 5 cycles -> in_ready=0, out_tile stable, no extra ctrl pulse; out_ready=1 -> FILL next cycle.
REQ-036 SHALL cover: 3 rows, abort, then 8 new rows -> tile contains only the 8 new rows, row 0 at out_tile[0].
REQ-037 SHALL cover: rst low after 5 rows -> out_valid=0, in_ready=1 immediately; next 8 rows form a clean tile.
REQ-038 SHALL cover, with TILE_LOADER_DOUBLE_BUF_EN: 24 back-to-back rows with out_ready held 0 -> in_ready falls after row 16; releasing out_ready -> tiles 1 and 2 delivered in order, 2 ctrl pulses.
REQ-039 SHALL cover: abort and last-row acceptance in the same cycle -> no out_valid, row counter 0.
